mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 106 ++++++++++
 tb/tb_mem_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MIPS-style MEM stage with address checking, bus FSM, load extension and ack watchdog.
module mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Valid_MEM,
   input  logic [3:0]  MemOp_MEM,
   input  logic [31:0] Addr_MEM,
   input  logic [31:0] WData_MEM,
   input  logic [4:0]  ExcCode_in,
   input  logic        Flush,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        Stall_MEM,
   output logic        Done_MEM,
   output logic [31:0] RData_MEM,
   output logic [4:0]  ExcCode_out,
   output logic [31:0] BadVAddr_MEM
);
   localparam int W = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_n;
   logic [W-1:0] wd;
   logic [31:0] addr_q, ld, ram_rdata;
   logic [3:0] op_q, be_n;
   logic [31:0] wdata_n;
   logic [15:0] half;
   logic [7:0] byte_v;
   logic killed, dbe, is_mem, is_store, is_word, is_half, io, legal, fault, accept, tmo;
   logic [4:0] idle_exc;
   logic idle_bad;
   assign is_mem   = MemOp_MEM inside {[4'd1:4'd8]};
   assign is_store = MemOp_MEM inside {[4'd6:4'd8]};
   assign is_word  = MemOp_MEM == 4'd1 || MemOp_MEM == 4'd6;
   assign is_half  = MemOp_MEM inside {4'd2, 4'd3, 4'd7};
   assign io       = (Addr_MEM >= 32'h7F00 && Addr_MEM <= 32'h7F0B) || (Addr_MEM >= 32'h7F10 && Addr_MEM <= 32'h7F1B);
   assign legal    = Addr_MEM < 32'h3000 || io;
   // Device registers are word-only; the two count registers are read-only.
   assign fault = (is_word && Addr_MEM[1:0] != 2'b00) || (is_half && Addr_MEM[0]) || !legal ||
                  (io && !is_word) || (is_store && (Addr_MEM == 32'h7F08 || Addr_MEM == 32'h7F18));
   assign accept = state == IDLE && Valid_MEM && is_mem && ExcCode_in == 5'd0 && !Flush && !fault;
   assign tmo = state == BUSY && !bus_ack && wd == W'(TIMEOUT - 1);
   assign be_n = is_word ? 4'hF : is_half ? (Addr_MEM[1] ? 4'hC : 4'h3) : 4'b0001 << Addr_MEM[1:0];
   assign wdata_n = is_word ? WData_MEM : is_half ? {2{WData_MEM[15:0]}} : {4{WData_MEM[7:0]}};
   assign ram_rdata = bus_rdata;
   assign half = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
   assign byte_v = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
   assign ld = op_q == 4'd1 ? ram_rdata :
               op_q == 4'd2 ? {{16{half[15]}}, half} :
               op_q == 4'd3 ? {16'h0, half} :
               op_q == 4'd4 ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
   assign bus_addr = {addr_q[31:2], 2'b00};
   assign idle_exc = ExcCode_in != 5'd0 ? ExcCode_in : (Valid_MEM && is_mem && fault) ? (is_store ? 5'd5 : 5'd4) : 5'd0;
   assign idle_bad = Valid_MEM && ExcCode_in == 5'd0 && is_mem && fault;
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state == IDLE ? (accept ? BUSY : IDLE) : state == BUSY ? ((bus_ack || tmo) ? DONE : BUSY) : IDLE;
   end
   // Outputs are gated by reset so they clear immediately, not at the next edge.
   always_comb begin
      bus_req      = reset && state == BUSY;
      Stall_MEM    = reset && (state == BUSY || accept);
      Done_MEM     = reset && (state == IDLE ? Valid_MEM && !Flush && !accept : state == DONE && !Flush && !killed);
      ExcCode_out  = !reset ? 5'd0 : state == IDLE ? idle_exc : (state == DONE && dbe) ? 5'd7 : 5'd0;
      BadVAddr_MEM = !reset ? 32'h0 : (state == IDLE && idle_bad) ? Addr_MEM : (state == DONE && dbe) ? addr_q : 32'h0;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         addr_q    <= '0;
         op_q      <= '0;
         bus_we    <= 1'b0;
         bus_be    <= '0;
         bus_wdata <= '0;
         wd        <= '0;
         killed    <= 1'b0;
         dbe       <= 1'b0;
         RData_MEM <= '0;
      end else begin
         if (accept) begin
            addr_q    <= Addr_MEM;
            op_q      <= MemOp_MEM;
            bus_we    <= is_store;
            bus_be    <= be_n;
            bus_wdata <= wdata_n;
            wd        <= '0;
            killed    <= 1'b0;
            dbe       <= 1'b0;
         end
         if (state == BUSY) begin
            if (Flush) killed <= 1'b1;
            if (bus_ack) RData_MEM <= ld;
            else begin
               wd <= wd + 1'b1;
               if (tmo) dbe <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
   logic clk = 1'b0, reset = 1'b0;
   logic Valid_MEM, Flush, bus_ack;
   logic [3:0] MemOp_MEM;
   logic [31:0] Addr_MEM, WData_MEM, bus_rdata;
   logic [4:0] ExcCode_in;
   logic bus_req, bus_we, Stall_MEM, Done_MEM;
   logic [31:0] bus_addr, bus_wdata, RData_MEM, BadVAddr_MEM;
   logic [3:0] bus_be;
   logic [4:0] ExcCode_out;
   int n_chk = 0, n_fail = 0;

   mem_stage #(.TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .Valid_MEM(Valid_MEM), .MemOp_MEM(MemOp_MEM), .Addr_MEM(Addr_MEM),
      .WData_MEM(WData_MEM), .ExcCode_in(ExcCode_in), .Flush(Flush), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .Stall_MEM(Stall_MEM), .Done_MEM(Done_MEM), .RData_MEM(RData_MEM), .ExcCode_out(ExcCode_out),
      .BadVAddr_MEM(BadVAddr_MEM)
   );

   always #5 clk = ~clk;

   localparam logic [3:0]  LD_OP  [7] = '{4'd4, 4'd5, 4'd2, 4'd2, 4'd3, 4'd1, 4'd1};
   localparam logic [31:0] LD_A   [7] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h12, 32'h10, 32'h7F18};
   localparam logic [3:0]  LD_BE  [7] = '{4'h8, 4'h8, 4'hC, 4'h3, 4'hC, 4'hF, 4'hF};
   localparam logic [31:0] LD_EXP [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                                          32'h0000_80FF, 32'h80FF_7F01, 32'h80FF_7F01};
   localparam logic [3:0]  ST_OP  [4] = '{4'd7, 4'd8, 4'd6, 4'd6};
   localparam logic [31:0] ST_A   [4] = '{32'h102, 32'h2001, 32'h2FFC, 32'h7F10};
   localparam logic [31:0] ST_D   [4] = '{32'h1234_ABCD, 32'h1234_565A, 32'hDEAD_BEEF, 32'h0BAD_F00D};
   localparam logic [3:0]  ST_BE  [4] = '{4'hC, 4'h2, 4'hF, 4'hF};
   localparam logic [31:0] ST_WD  [4] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'hDEAD_BEEF, 32'h0BAD_F00D};
   localparam logic [31:0] ST_BA  [4] = '{32'h100, 32'h2000, 32'h2FFC, 32'h7F10};
   localparam logic [3:0]  F_OP   [11] = '{4'd1, 4'd6, 4'd2, 4'd8, 4'd4, 4'd6, 4'd3, 4'd1, 4'd6, 4'd0, 4'd9};
   localparam logic [31:0] F_A    [11] = '{32'h6, 32'h7F08, 32'h101, 32'h3000, 32'h7F00, 32'h7F0C, 32'h7F14,
                                           32'h0, 32'h7F08, 32'h6, 32'h3001};
   localparam logic [4:0]  F_EIN  [11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd10, 5'd3, 5'd0, 5'd0};
   localparam logic [4:0]  F_EXC  [11] = '{5'd4, 5'd5, 5'd4, 5'd5, 5'd4, 5'd5, 5'd4, 5'd10, 5'd3, 5'd0, 5'd0};
   localparam logic [31:0] F_BAD  [11] = '{32'h6, 32'h7F08, 32'h101, 32'h3000, 32'h7F00, 32'h7F0C, 32'h7F14,
                                           32'h0, 32'h0, 32'h0, 32'h0};

   task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] e, input logic f);
      Valid_MEM = v; MemOp_MEM = op; Addr_MEM = a; WData_MEM = d; ExcCode_in = e; Flush = f;
   endtask

   task automatic idle_in();
      drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
   endtask

   task automatic test_reset();
      drive(1'b1, 4'd1, 32'h0, 32'h0, 5'd0, 1'b0);
      bus_ack = 1'b0; bus_rdata = 32'h0;
      @(negedge clk); #1;
      n_chk++;
      if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, Stall_MEM, Done_MEM, RData_MEM, ExcCode_out, BadVAddr_MEM} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: req=%b stall=%b done=%b exc=%0d be=%h, required all zero",
                            bus_req, Stall_MEM, Done_MEM, ExcCode_out, bus_be);
      end
      @(negedge clk);
      reset = 1'b1; idle_in();
   endtask

   task automatic test_loads();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         drive(1'b1, LD_OP[i], LD_A[i], 32'h0, 5'd0, 1'b0);
         #1; n_chk++;
         if (Stall_MEM !== 1'b1 || Done_MEM !== 1'b0) begin
            n_fail++; $display("FAIL load%0d_accept: stall=%b done=%b, required 1/0", i, Stall_MEM, Done_MEM);
         end
         @(negedge clk);
         idle_in(); bus_ack = 1'b1; bus_rdata = 32'h80FF_7F01;
         #1; n_chk++;
         if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_be !== LD_BE[i] || bus_addr !== {LD_A[i][31:2], 2'b00}) begin
            n_fail++; $display("FAIL load%0d_bus: req=%b we=%b be=%h addr=%h, required 1/0/%h/%h",
                               i, bus_req, bus_we, bus_be, bus_addr, LD_BE[i], {LD_A[i][31:2], 2'b00});
         end
         @(negedge clk);
         bus_ack = 1'b0;
         #1; n_chk++;
         if (Done_MEM !== 1'b1 || Stall_MEM !== 1'b0 || RData_MEM !== LD_EXP[i] || ExcCode_out !== 5'd0) begin
            n_fail++; $display("FAIL load%0d_done: done=%b stall=%b rdata=%h exc=%0d, required 1/0/%h/0",
                               i, Done_MEM, Stall_MEM, RData_MEM, ExcCode_out, LD_EXP[i]);
         end
      end
      @(negedge clk); #1; n_chk++;
      if (Done_MEM !== 1'b0 || bus_req !== 1'b0) begin
         n_fail++; $display("FAIL load_return_idle: done=%b req=%b, required 0/0", Done_MEM, bus_req);
      end
   endtask

   task automatic test_stores();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1'b1, ST_OP[i], ST_A[i], ST_D[i], 5'd0, 1'b0);
         @(negedge clk);
         idle_in(); bus_ack = 1'b0;
         #1; n_chk++;
         if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_be !== ST_BE[i] || bus_wdata !== ST_WD[i] || bus_addr !== ST_BA[i]) begin
            n_fail++; $display("FAIL store%0d_bus: req=%b we=%b be=%h wdata=%h addr=%h, required 1/1/%h/%h/%h",
                               i, bus_req, bus_we, bus_be, bus_wdata, bus_addr, ST_BE[i], ST_WD[i], ST_BA[i]);
         end
         @(negedge clk);
         bus_ack = 1'b1;
         #1; n_chk++;
         if (Stall_MEM !== 1'b1 || {bus_be, bus_wdata, bus_addr} !== {ST_BE[i], ST_WD[i], ST_BA[i]}) begin
            n_fail++; $display("FAIL store%0d_stable: stall=%b be=%h wdata=%h addr=%h, required 1/%h/%h/%h",
                               i, Stall_MEM, bus_be, bus_wdata, bus_addr, ST_BE[i], ST_WD[i], ST_BA[i]);
         end
         @(negedge clk);
         bus_ack = 1'b0;
         #1; n_chk++;
         if (Done_MEM !== 1'b1 || ExcCode_out !== 5'd0 || bus_req !== 1'b0) begin
            n_fail++; $display("FAIL store%0d_done: done=%b exc=%0d req=%b, required 1/0/0", i, Done_MEM, ExcCode_out, bus_req);
         end
      end
   endtask

   task automatic test_faults();
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         drive(1'b1, F_OP[i], F_A[i], 32'h5555_5555, F_EIN[i], 1'b0);
         #1; n_chk++;
         if (ExcCode_out !== F_EXC[i] || BadVAddr_MEM !== F_BAD[i] || Stall_MEM !== 1'b0 || Done_MEM !== 1'b1 || bus_req !== 1'b0) begin
            n_fail++; $display("FAIL fault%0d: exc=%0d bad=%h stall=%b done=%b req=%b, required %0d/%h/0/1/0",
                               i, ExcCode_out, BadVAddr_MEM, Stall_MEM, Done_MEM, bus_req, F_EXC[i], F_BAD[i]);
         end
      end
      @(negedge clk);
      idle_in();
      #1; n_chk++;
      if (bus_req !== 1'b0 || Done_MEM !== 1'b0) begin
         n_fail++; $display("FAIL fault_no_bus: req=%b done=%b, required 0/0", bus_req, Done_MEM);
      end
   endtask

   task automatic test_timeout();
      int cnt = 0;
      logic seen = 1'b0;
      logic [4:0] exc = '0;
      logic [31:0] bad = '0;
      @(negedge clk);
      drive(1'b1, 4'd1, 32'h20, 32'h0, 5'd0, 1'b0);
      bus_ack = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         idle_in();
         #1;
         if (bus_req) cnt++;
         else begin
            seen = Done_MEM; exc = ExcCode_out; bad = BadVAddr_MEM;
            break;
         end
      end
      n_chk++;
      if (cnt !== 16) begin
         n_fail++; $display("FAIL timeout_req_cycles: got %0d, required 16", cnt);
      end
      n_chk++;
      if (seen !== 1'b1 || exc !== 5'd7 || bad !== 32'h20) begin
         n_fail++; $display("FAIL timeout_done: done=%b exc=%0d bad=%h, required 1/7/00000020", seen, exc, bad);
      end
   endtask

   task automatic test_ack_at_timeout();
      @(negedge clk);
      drive(1'b1, 4'd1, 32'h24, 32'h0, 5'd0, 1'b0);
      bus_ack = 1'b0;
      repeat (15) begin
         @(negedge clk);
         idle_in();
      end
      @(negedge clk);
      bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
      #1; n_chk++;
      if (bus_req !== 1'b1) begin
         n_fail++; $display("FAIL ack_at_timeout_req: req=%b, required 1", bus_req);
      end
      @(negedge clk);
      bus_ack = 1'b0;
      #1; n_chk++;
      if (Done_MEM !== 1'b1 || ExcCode_out !== 5'd0 || RData_MEM !== 32'h1122_3344) begin
         n_fail++; $display("FAIL ack_at_timeout_done: done=%b exc=%0d rdata=%h, required 1/0/11223344",
                            Done_MEM, ExcCode_out, RData_MEM);
      end
   endtask

   task automatic test_flush();
      @(negedge clk);
      drive(1'b1, 4'd1, 32'h40, 32'h0, 5'd0, 1'b0);
      bus_ack = 1'b0;
      @(negedge clk);
      idle_in();
      @(negedge clk);
      Flush = 1'b1;
      @(negedge clk);
      Flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFE_0001;
      #1; n_chk++;
      if (bus_req !== 1'b1 || Stall_MEM !== 1'b1) begin
         n_fail++; $display("FAIL flush_busy_continues: req=%b stall=%b, required 1/1", bus_req, Stall_MEM);
      end
      @(negedge clk);
      bus_ack = 1'b0;
      #1; n_chk++;
      if (Done_MEM !== 1'b0 || Stall_MEM !== 1'b0 || bus_req !== 1'b0) begin
         n_fail++; $display("FAIL flush_busy_done: done=%b stall=%b req=%b, required 0/0/0", Done_MEM, Stall_MEM, bus_req);
      end
      @(negedge clk);
      drive(1'b1, 4'd1, 32'h44, 32'h0, 5'd0, 1'b0);
      @(negedge clk);
      idle_in(); bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0; Flush = 1'b1;
      #1; n_chk++;
      if (Done_MEM !== 1'b0) begin
         n_fail++; $display("FAIL flush_in_done: done=%b, required 0", Done_MEM);
      end
      @(negedge clk);
      drive(1'b1, 4'd1, 32'h48, 32'h0, 5'd0, 1'b1);
      #1; n_chk++;
      if (Stall_MEM !== 1'b0 || Done_MEM !== 1'b0) begin
         n_fail++; $display("FAIL flush_in_idle: stall=%b done=%b, required 0/0", Stall_MEM, Done_MEM);
      end
      @(negedge clk);
      idle_in();
      #1; n_chk++;
      if (bus_req !== 1'b0) begin
         n_fail++; $display("FAIL flush_blocks_accept: req=%b, required 0", bus_req);
      end
   endtask

   task automatic test_reset_busy();
      @(negedge clk);
      drive(1'b1, 4'd6, 32'h80, 32'h7777_8888, 5'd0, 1'b0);
      bus_ack = 1'b0;
      @(negedge clk);
      idle_in();
      #1; n_chk++;
      if (bus_req !== 1'b1) begin
         n_fail++; $display("FAIL rst_busy_pre: req=%b, required 1", bus_req);
      end
      #1 reset = 1'b0;
      #1; n_chk++;
      if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, Stall_MEM, Done_MEM, RData_MEM, ExcCode_out, BadVAddr_MEM} !== '0) begin
         n_fail++; $display("FAIL rst_busy_immediate: req=%b we=%b be=%h addr=%h stall=%b, required all zero",
                            bus_req, bus_we, bus_be, bus_addr, Stall_MEM);
      end
      @(negedge clk);
      reset = 1'b1;
      #1; n_chk++;
      if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, Stall_MEM, Done_MEM, RData_MEM, ExcCode_out, BadVAddr_MEM} !== '0) begin
         n_fail++; $display("FAIL rst_release_outputs: req=%b we=%b be=%h addr=%h wdata=%h, required all zero",
                            bus_req, bus_we, bus_be, bus_addr, bus_wdata);
      end
      @(negedge clk);
      drive(1'b1, 4'd1, 32'h84, 32'h0, 5'd0, 1'b0);
      #1; n_chk++;
      if (Stall_MEM !== 1'b1) begin
         n_fail++; $display("FAIL rst_release_idle_accept: stall=%b, required 1", Stall_MEM);
      end
      @(negedge clk);
      idle_in(); bus_ack = 1'b1; bus_rdata = 32'h0000_00A5;
      @(negedge clk);
      bus_ack = 1'b0;
      #1; n_chk++;
      if (Done_MEM !== 1'b1 || RData_MEM !== 32'hA5) begin
         n_fail++; $display("FAIL rst_release_load: done=%b rdata=%h, required 1/000000a5", Done_MEM, RData_MEM);
      end
   endtask

   initial begin
      test_reset();
      test_loads();
      test_stores();
      test_faults();
      test_timeout();
      test_ack_at_timeout();
      test_flush();
      test_reset_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
